sz_stream_decode: RTL and testbench

Decompression-side reconstruction stage for the SZ pipeline. It consumes the per-point stream of predictor-select and quantization code, or a raw value for unpredictable points, produced by the compression front end. It rebuilds fixed-point data values with the same curve-fitting predictors the encoder used. The block sits where the compressed stream re-enters the fabric and feeds the reconstructed values downstream through a valid/ready interface.

---
 rtl/sz_dec_pkg.sv | 26 ++
 rtl/sz_predictor.sv | 34 +++
 rtl/sz_stream_decode.sv | 130 +++++++++++++
 tb/tb_sz_stream_decode.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sz_dec_pkg.sv
// Shared constants, mode encoding and width helpers for the SZ decode/encode datapath.
package sz_dec_pkg;

    typedef enum logic [1:0] {
        MODE_RAW  = 2'd0,
        MODE_ORD0 = 2'd1,
        MODE_LIN  = 2'd2,
        MODE_QUAD = 2'd3
    } mode_e;

    // Extra bits so that 3*h1 - 3*h2 + h3 cannot overflow.
    localparam int unsigned PRED_GUARD = 3;

    function automatic int radius(input int qbits);
        return 1 << (qbits - 1);
    endfunction

    function automatic int pred_w(input int width);
        return width + PRED_GUARD;
    endfunction

    function automatic int recon_w(input int width, input int qbits, input int shift);
        return width + qbits + shift + PRED_GUARD;
    endfunction

endpackage

// File: rtl/sz_predictor.sv
// Combinational curve-fitting predictor shared by the SZ encoder and decoder.
module sz_predictor
    import sz_dec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH-1:0]         h1_i,
    input  logic signed [WIDTH-1:0]         h2_i,
    input  logic signed [WIDTH-1:0]         h3_i,
    input  logic        [1:0]               mode_i,
    output logic signed [pred_w(WIDTH)-1:0] p_o
);

    localparam int PW = pred_w(WIDTH);

    logic signed [PW-1:0] e1, e2, e3;
    mode_e mode;

    assign e1   = {{PRED_GUARD{h1_i[WIDTH-1]}}, h1_i};
    assign e2   = {{PRED_GUARD{h2_i[WIDTH-1]}}, h2_i};
    assign e3   = {{PRED_GUARD{h3_i[WIDTH-1]}}, h3_i};
    assign mode = mode_e'(mode_i);

    always_comb begin
        p_o = '0;
        case (mode)
            MODE_ORD0: p_o = e1;
            MODE_LIN:  p_o = (e1 <<< 1) - e2;
            MODE_QUAD: p_o = (e1 <<< 1) + e1 - (e2 <<< 1) - e2 + e3;
            default:   p_o = '0;
        endcase
    end

endmodule

// File: rtl/sz_stream_decode.sv
// SZ reconstruction stage: valid/ready stream of mode/code/raw in, fixed-point values out.
// Define SZ_DEC_SAT_EN to saturate reconstructed values instead of wrapping them.
module sz_stream_decode
    import sz_dec_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int QBITS      = 16,
    parameter int ERR2_SHIFT = 2,
    parameter int BLOCK_LEN  = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic [QBITS-1:0]        in_code,
    input  logic signed [WIDTH-1:0] in_raw,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last
);

    localparam int PW     = pred_w(WIDTH);
    localparam int RW     = recon_w(WIDTH, QBITS, ERR2_SHIFT);
    localparam int CW     = $clog2(BLOCK_LEN);
    localparam int RADIUS = radius(QBITS);

    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] h1_q, h2_q, h3_q, h1_d, h2_d, h3_d;
    logic signed [WIDTH-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic                    accept;
    logic                    at_last;
    logic signed [PW-1:0]    pred;
    logic signed [RW-1:0]    code_w, delta, recon_full;
    logic signed [WIDTH-1:0] recon;

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign at_last   = (cnt_q == CW'(BLOCK_LEN - 1));
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

    sz_predictor #(.WIDTH(WIDTH)) u_pred (
        .h1_i   (h1_q),
        .h2_i   (h2_q),
        .h3_i   (h3_q),
        .mode_i (in_mode),
        .p_o    (pred)
    );

    // The code is unsigned, so it is zero-extended before re-centring on RADIUS.
    assign code_w     = $signed({{(RW-QBITS){1'b0}}, in_code});
    assign delta      = (code_w - RW'(RADIUS)) <<< ERR2_SHIFT;
    assign recon_full = {{(RW-PW){pred[PW-1]}}, pred} + delta;

    always_comb begin
        recon = '0;
        if (mode_e'(in_mode) == MODE_RAW) begin
            recon = in_raw;
        end else begin
`ifdef SZ_DEC_SAT_EN
            if (recon_full > SAT_MAX)
                recon = WIDTH'(SAT_MAX);
            else if (recon_full < SAT_MIN)
                recon = WIDTH'(SAT_MIN);
            else
                recon = WIDTH'(recon_full);
`else
            recon = WIDTH'(recon_full);
`endif
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        h1_d    = h1_q;
        h2_d    = h2_q;
        h3_d    = h3_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = recon;
            last_d  = at_last;
            if (at_last) begin
                cnt_d = '0;
                h1_d  = '0;
                h2_d  = '0;
                h3_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                h1_d  = recon;
                h2_d  = h1_q;
                h3_d  = h2_q;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
            h3_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            h3_q    <= h3_d;
        end
    end

endmodule

// File: tb/tb_sz_stream_decode.sv
// Directed bench for sz_stream_decode with BLOCK_LEN = 4 and default quantizer settings.
module tb_sz_stream_decode;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [15:0] in_code;
    logic [31:0] in_raw;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    sz_stream_decode #(
        .WIDTH      (32),
        .QBITS      (16),
        .ERR2_SHIFT (2),
        .BLOCK_LEN  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_code   (in_code),
        .in_raw    (in_raw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every value handed downstream while enabled.
    logic        col_en = 1'b0;
    logic [31:0] col_q[$];
    always @(posedge clk) begin
        if (col_en && rst && out_valid && out_ready)
            col_q.push_back(out_data);
    end

    typedef struct {
        logic        rst_b4;
        logic [1:0]  mode;
        logic [15:0] code;
        logic [31:0] raw;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input logic [15:0] c, input logic [31:0] r);
        in_valid = 1'b1;
        in_mode  = m;
        in_code  = c;
        in_raw   = r;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] ovf_exp;

    initial begin
`ifdef SZ_DEC_SAT_EN
        ovf_exp = 32'h7FFF_FFFF;
`else
        ovf_exp = 32'h8000_0180;
`endif
        //            rst   mode  code    raw            exp           last
        vecs[0]  = '{1'b1, 2'd1, 16'd32773, 32'h0,         32'd20,        1'b0};
        vecs[1]  = '{1'b0, 2'd2, 16'd32768, 32'h0,         32'd40,        1'b0};
        vecs[2]  = '{1'b0, 2'd3, 16'd32767, 32'h0,         32'd56,        1'b0};
        vecs[3]  = '{1'b1, 2'd0, 16'hBEEF,  32'hFFFF_FFF9, 32'hFFFF_FFF9, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 16'd32768, 32'h0,         32'hFFFF_FFF9, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 16'd32769, 32'h0,         32'd4,         1'b0};
        vecs[6]  = '{1'b0, 2'd1, 16'd32769, 32'h0,         32'd8,         1'b0};
        vecs[7]  = '{1'b0, 2'd2, 16'd32768, 32'h0,         32'd12,        1'b0};
        vecs[8]  = '{1'b0, 2'd3, 16'd32768, 32'h0,         32'd16,        1'b1};
        vecs[9]  = '{1'b0, 2'd2, 16'd32769, 32'h0,         32'd4,         1'b0};
        vecs[10] = '{1'b0, 2'd1, 16'd32770, 32'h0,         32'd12,        1'b0};
        vecs[11] = '{1'b1, 2'd0, 16'd0,     32'h7FFF_FFF0, 32'h7FFF_FFF0, 1'b0};
        vecs[12] = '{1'b0, 2'd1, 16'd32868, 32'h0,         ovf_exp,       1'b0};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_mode = 2'd0; in_code = '0; in_raw = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst_b4) do_reset();
            drive(vecs[i].mode, vecs[i].code, vecs[i].raw);
            #1;
            chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
            chk($sformatf("vec%0d out_last", i), {31'd0, out_last}, {31'd0, vecs[i].exp_last});
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain out_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: 3-cycle stall mid-stream, five values across a block boundary.
        do_reset();
        col_q.delete();
        col_en = 1'b1;
        drive(2'd0, 16'd0, 32'd10);
        @(posedge clk); #1;
        drive(2'd1, 16'd32769, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'd2, 16'd32768, 32'd0);
        #1;
        chk("bp in_ready stalled", {31'd0, in_ready}, 32'd0);
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d out_valid", s), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp hold%0d out_data", s), out_data, 32'd14);
            chk($sformatf("bp hold%0d in_ready", s), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready resumed", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp p2 data", out_data, 32'd18);
        drive(2'd1, 16'd32767, 32'd0);
        @(posedge clk); #1;
        chk("bp p3 data", out_data, 32'd14);
        chk("bp p3 last", {31'd0, out_last}, 32'd1);
        drive(2'd0, 16'd0, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("bp p4 data", out_data, 32'hFFFF_FFFF);
        chk("bp p4 last", {31'd0, out_last}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp drained", {31'd0, out_valid}, 32'd0);
        col_en = 1'b0;
        exp_q = '{32'd10, 32'd14, 32'd18, 32'd14, 32'hFFFF_FFFF};
        chk("bp delivered count", col_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < col_q.size())
                chk($sformatf("bp delivered%0d", k), col_q[k], exp_q[k]);
        end

        // Mid-block reset with a beat still offered: state must clear.
        do_reset();
        drive(2'd1, 16'd32769, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid pre-reset data", out_data, 32'd8);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid reset out_data", out_data, 32'd0);
        chk("mid reset out_last", {31'd0, out_last}, 32'd0);
        chk("mid reset in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        drive(2'd2, 16'd32769, 32'd0);
        @(posedge clk); #1;
        chk("mid post p0 data", out_data, 32'd4);
        chk("mid post p0 last", {31'd0, out_last}, 32'd0);
        drive(2'd1, 16'd32768, 32'd0);
        for (int j = 1; j < 4; j++) begin
            @(posedge clk); #1;
            chk($sformatf("mid post p%0d data", j), out_data, 32'd4);
            chk($sformatf("mid post p%0d last", j), {31'd0, out_last}, (j == 3) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
